// File: rtl/inst_encoder.sv
// rtl/inst_encoder.sv - RV32I instruction word encoder with immediate range checks
// and a two-stage valid/ready pipeline feeding an auto-incrementing imem write port.
module inst_encoder #(
    parameter int                 ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
    parameter int                 CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_sticky,
    output logic [CNT_W-1:0]  inst_count,
    output logic [CNT_W-1:0]  err_count
);

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] FMT_IALU = 3'd0;
    localparam logic [2:0] FMT_LOAD = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_JAL  = 3'd4;
    localparam logic [2:0] FMT_JALR = 3'd5;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic signed [31:0] simm;
    logic               fits12;
    logic               fits13;
    logic               fits21;
    logic               is_shift;
    logic               addi_hazard;
    logic [31:0]        enc_inst;
    logic               enc_err;

    logic               a_vld;
    logic               a_err;
    logic [31:0]        a_inst;

    logic               b_free;
    logic               accept;
    logic               a_adv;
    logic               b_load;
    logic               drop;
    logic               deliver;

    assign simm     = imm;
    assign fits12   = (imm[31:11] == {21{imm[11]}});
    assign fits13   = (imm[31:12] == {20{imm[12]}});
    assign fits21   = (imm[31:20] == {12{imm[20]}});
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
    // ADDI immediates in this window collide with the decoder's negated-field case.
    assign addi_hazard = (simm >= -32'sd1024) && (simm <= -32'sd993);

    always_comb begin
        enc_inst = '0;
        enc_err  = 1'b0;
        case (fmt)
            FMT_IALU: begin
                if (is_shift) begin
                    enc_inst = {funct7, imm[4:0], rs1, funct3, rd, OP_IMM};
                    enc_err  = (imm[31:5] != 27'd0);
                end else begin
                    enc_inst = {imm[11:0], rs1, funct3, rd, OP_IMM};
                    enc_err  = !fits12 || ((funct3 == 3'b000) && addi_hazard);
                end
            end
            FMT_LOAD: begin
                enc_inst = {imm[11:0], rs1, funct3, rd, OP_LOAD};
                enc_err  = !fits12;
            end
            FMT_S: begin
                enc_inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
                enc_err  = !fits12;
            end
            FMT_B: begin
                enc_inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
                enc_err  = !fits13 || imm[0];
            end
            FMT_JAL: begin
                enc_inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
                enc_err  = !fits21 || imm[0];
            end
            FMT_JALR: begin
                enc_inst = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
                enc_err  = !fits12;
            end
            default: begin
                enc_inst = '0;
                enc_err  = 1'b1;
            end
        endcase
    end

    assign b_free   = !out_valid || out_ready;
    assign in_ready = !a_vld || b_free;
    assign accept   = in_valid && in_ready;
    assign a_adv    = a_vld && b_free;
    assign b_load   = a_adv && !a_err;
    assign drop     = a_adv && a_err;
    assign deliver  = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_vld  <= 1'b0;
            a_err  <= 1'b0;
            a_inst <= '0;
        end else if (accept) begin
            a_vld  <= 1'b1;
            a_err  <= enc_err;
            a_inst <= enc_inst;
        end else if (a_adv) begin
            a_vld  <= 1'b0;
        end
    end

    // Output register holds its word until the sink takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_inst  <= '0;
        end else if (b_load) begin
            out_valid <= 1'b1;
            out_inst  <= a_inst;
        end else if (deliver) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_addr <= BASE_ADDR;
        end else if (deliver) begin
            out_addr <= out_addr + ADDR_W'(4);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_count <= '0;
            err_count  <= '0;
            err_sticky <= 1'b0;
        end else begin
            if (deliver && (inst_count != CNT_MAX)) begin
                inst_count <= inst_count + 1'b1;
            end
            if (drop && (err_count != CNT_MAX)) begin
                err_count <= err_count + 1'b1;
            end
            if (drop) begin
                err_sticky <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// tb/tb_inst_encoder.sv - scoreboard bench for inst_encoder
module tb_inst_encoder;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  fmt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_addr;
    logic        err_sticky;
    logic [15:0] inst_count;
    logic [15:0] err_count;

    inst_encoder #(.ADDR_W(32), .BASE_ADDR(BASE), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_addr(out_addr),
        .err_sticky(err_sticky), .inst_count(inst_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f;
        logic [4:0]  d;
        logic [4:0]  s1;
        logic [4:0]  s2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] im;
        bit          good;
        logic [31:0] ex;
    } req_t;

    int          total = 0;
    int          bad = 0;
    logic [31:0] q_inst[$];
    logic [31:0] exp_addr;
    logic [31:0] mon_exp;
    int          delivered;
    int          exp_err;

    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (q_inst.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word: got inst=%h addr=%h, required no word", out_inst, out_addr);
            end else begin
                mon_exp = q_inst.pop_front();
                total++;
                if (out_inst !== mon_exp) begin
                    bad++;
                    $display("FAIL out_inst: got %h required %h", out_inst, mon_exp);
                end
                total++;
                if (out_addr !== exp_addr) begin
                    bad++;
                    $display("FAIL out_addr: got %h required %h", out_addr, exp_addr);
                end
                exp_addr  = exp_addr + 32'd4;
                delivered = delivered + 1;
            end
        end
    end

    function automatic req_t mk(input logic [2:0] f, input logic [4:0] d, input logic [4:0] s1,
                                input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] im, input bit good, input logic [31:0] ex);
        req_t r;
        r.f = f; r.d = d; r.s1 = s1; r.s2 = s2; r.f3 = f3; r.f7 = f7;
        r.im = im; r.good = good; r.ex = ex;
        return r;
    endfunction

    task automatic drive(input req_t r);
        fmt = r.f; rd = r.d; rs1 = r.s1; rs2 = r.s2;
        funct3 = r.f3; funct7 = r.f7; imm = r.im;
        in_valid = 1'b1;
    endtask

    task automatic send(input req_t r, output int waits);
        bit acc;
        acc   = 1'b0;
        waits = 0;
        drive(r);
        while (!acc && waits < 200) begin
            if (in_ready === 1'b1) begin
                acc = 1'b1;
            end else begin
                @(posedge clk); #1;
                waits++;
            end
        end
        if (acc) begin
            if (r.good) q_inst.push_back(r.ex);
            else exp_err++;
            @(posedge clk); #1;
        end else begin
            total++;
            bad++;
            $display("FAIL send_timeout: got in_ready=%b, required 1 within 200 cycles", in_ready);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q_inst.size() != 0 || out_valid === 1'b1) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (q_inst.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d words outstanding, required 0", q_inst.size());
        end
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        fmt = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; imm = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        q_inst.delete();
        exp_addr  = BASE;
        delivered = 0;
        exp_err   = 0;
        rst_n     = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b required 1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
        total++; if (out_inst !== 32'h0) begin bad++; $display("FAIL rst_out_inst: got %h required 0", out_inst); end
        total++; if (out_addr !== BASE) begin bad++; $display("FAIL rst_out_addr: got %h required %h", out_addr, BASE); end
        total++; if (err_sticky !== 1'b0) begin bad++; $display("FAIL rst_err_sticky: got %b required 0", err_sticky); end
        total++; if (inst_count !== 16'd0) begin bad++; $display("FAIL rst_inst_count: got %0d required 0", inst_count); end
        total++; if (err_count !== 16'd0) begin bad++; $display("FAIL rst_err_count: got %0d required 0", err_count); end
    endtask

    task automatic test_latency();
        int w;
        out_ready = 1'b0;
        send(mk(3'd0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1, 32'h00500093), w);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_early: got out_valid=%b required 0", out_valid); end
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL lat_valid: got %b required 1", out_valid); end
        total++; if (out_inst !== 32'h00500093) begin bad++; $display("FAIL lat_inst: got %h required 00500093", out_inst); end
        total++; if (out_addr !== BASE) begin bad++; $display("FAIL lat_addr: got %h required %h", out_addr, BASE); end
        out_ready = 1'b1;
        drain();
    endtask

    task automatic test_error_drop();
        int w;
        do_reset();
        send(mk(3'd2, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd2048, 1'b0, 32'h0), w);
        repeat (3) begin
            @(posedge clk); #1;
            total++;
            if (out_valid !== 1'b0) begin bad++; $display("FAIL drop_no_valid: got %b required 0", out_valid); end
        end
        total++; if (err_count !== 16'd1) begin bad++; $display("FAIL drop_err_count: got %0d required 1", err_count); end
        total++; if (err_sticky !== 1'b1) begin bad++; $display("FAIL drop_sticky: got %b required 1", err_sticky); end
        send(mk(3'd0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1, 32'h00500093), w);
        drain();
        total++; if (inst_count !== 16'd1) begin bad++; $display("FAIL drop_inst_count: got %0d required 1", inst_count); end
    endtask

    task automatic test_encode();
        req_t tbl[$];
        int   w;
        tbl.push_back(mk(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd4,    1'b1, 32'hFE208EE3));
        tbl.push_back(mk(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,   1'b1, 32'h001000EF));
        tbl.push_back(mk(3'd0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1000,   1'b1, 32'h3E800093));
        tbl.push_back(mk(3'd0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd1000, 1'b0, 32'h0));
        tbl.push_back(mk(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3,      1'b0, 32'h0));
        tbl.push_back(mk(3'd1, 5'd5, 5'd2, 5'd0, 3'd2, 7'd0, -32'sd8,    1'b1, 32'hFF812283));
        tbl.push_back(mk(3'd2, 5'd0, 5'd2, 5'd3, 3'd2, 7'd0, 32'd12,     1'b1, 32'h00312623));
        tbl.push_back(mk(3'd5, 5'd0, 5'd1, 5'd0, 3'd7, 7'd0, 32'd0,      1'b1, 32'h00008067));
        tbl.push_back(mk(3'd0, 5'd1, 5'd1, 5'd0, 3'd5, 7'h20, 32'd3,     1'b1, 32'h4030D093));
        tbl.push_back(mk(3'd0, 5'd2, 5'd3, 5'd0, 3'd1, 7'h00, 32'd31,    1'b1, 32'h01F19113));
        tbl.push_back(mk(3'd0, 5'd2, 5'd3, 5'd0, 3'd1, 7'h00, 32'd32,    1'b0, 32'h0));
        tbl.push_back(mk(3'd0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2047,   1'b1, 32'h7FF00093));
        tbl.push_back(mk(3'd0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,   1'b0, 32'h0));
        tbl.push_back(mk(3'd0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd2048, 1'b1, 32'h80000093));
        tbl.push_back(mk(3'd0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd1024, 1'b0, 32'h0));
        tbl.push_back(mk(3'd0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd993,  1'b0, 32'h0));
        tbl.push_back(mk(3'd0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd992,  1'b1, 32'hC2000093));
        tbl.push_back(mk(3'd0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd1025, 1'b1, 32'hBFF00093));
        tbl.push_back(mk(3'd3, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4094,   1'b1, 32'h7E000FE3));
        tbl.push_back(mk(3'd3, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096,   1'b0, 32'h0));
        tbl.push_back(mk(3'd4, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd2,    1'b1, 32'hFFFFF06F));
        tbl.push_back(mk(3'd4, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0000, 1'b0, 32'h0));
        tbl.push_back(mk(3'd5, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd2048,   1'b0, 32'h0));
        tbl.push_back(mk(3'd1, 5'd1, 5'd1, 5'd0, 3'd2, 7'd0, -32'sd2049, 1'b0, 32'h0));
        tbl.push_back(mk(3'd6, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0,      1'b0, 32'h0));
        tbl.push_back(mk(3'd7, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0,      1'b0, 32'h0));
        out_ready = 1'b1;
        foreach (tbl[i]) send(tbl[i], w);
        drain();
        total++; if (err_count !== 16'(exp_err)) begin bad++; $display("FAIL enc_err_count: got %0d required %0d", err_count, exp_err); end
        total++; if (inst_count !== 16'(delivered)) begin bad++; $display("FAIL enc_inst_count: got %0d required %0d", inst_count, delivered); end
        total++; if (err_sticky !== 1'b1) begin bad++; $display("FAIL enc_sticky: got %b required 1", err_sticky); end
    endtask

    task automatic test_back_to_back();
        int w;
        int stalls;
        stalls = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(mk(3'd0, 5'(i), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i * 16), 1'b1,
                    (32'(i * 16) << 20) | (32'(i) << 7) | 32'h13), w);
            stalls += w;
        end
        total++; if (stalls != 0) begin bad++; $display("FAIL b2b_stalls: got %0d stall cycles required 0", stalls); end
        drain();
    endtask

    task automatic test_stall();
        int          w;
        logic [31:0] held;
        do_reset();
        out_ready = 1'b0;
        send(mk(3'd0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1, 32'h00500093), w);
        send(mk(3'd0, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd6, 1'b1, 32'h00600113), w);
        drive(mk(3'd0, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7, 1'b1, 32'h00700193));
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready: got %b required 0", in_ready); end
        held = out_inst;
        total++; if (held !== 32'h00500093) begin bad++; $display("FAIL stall_head: got %h required 00500093", held); end
        repeat (3) begin
            @(posedge clk); #1;
            total++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_inst !== held) begin
                bad++;
                $display("FAIL stall_hold: got ready=%b valid=%b inst=%h required 0 1 %h", in_ready, out_valid, out_inst, held);
            end
        end
        q_inst.push_back(32'h00700193);
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();
        total++; if (out_addr !== BASE + 32'd12) begin bad++; $display("FAIL stall_addr_end: got %h required %h", out_addr, BASE + 32'd12); end
    endtask

    task automatic test_reset_midop();
        int w;
        out_ready = 1'b0;
        send(mk(3'd6, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b0, 32'h0), w);
        send(mk(3'd0, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd9, 1'b1, 32'h00900213), w);
        send(mk(3'd0, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd10, 1'b1, 32'h00A00293), w);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL midop_full: got in_ready=%b required 0", in_ready); end
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midop_valid: got %b required 0", out_valid); end
        total++; if (out_inst !== 32'h0) begin bad++; $display("FAIL midop_inst: got %h required 0", out_inst); end
        total++; if (out_addr !== BASE) begin bad++; $display("FAIL midop_addr: got %h required %h", out_addr, BASE); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midop_ready: got %b required 1", in_ready); end
        total++; if (err_sticky !== 1'b0) begin bad++; $display("FAIL midop_sticky: got %b required 0", err_sticky); end
        total++; if (err_count !== 16'd0) begin bad++; $display("FAIL midop_err_count: got %0d required 0", err_count); end
        q_inst.delete();
        exp_addr  = BASE;
        delivered = 0;
        exp_err   = 0;
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midop_stale: got out_valid=%b required 0", out_valid); end
        total++; if (inst_count !== 16'd0) begin bad++; $display("FAIL midop_inst_count: got %0d required 0", inst_count); end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        exp_addr  = BASE;
        delivered = 0;
        exp_err   = 0;
        test_reset();
        test_latency();
        test_error_drop();
        test_encode();
        test_back_to_back();
        test_stall();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion, required finish before 200000");
        $fatal(1);
    end

endmodule
